// File: rtl/spi_ser.sv
// SPI master serializer: single/dual/quad IO shifter with a command/response
// handshake, CPOL=0 clock generated from a programmable half-period divider.
module spi_ser #(
  parameter int unsigned DW  = 32,
  parameter int unsigned CDW = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [CDW-1:0] div,
  input  logic           cmd_vld,
  output logic           cmd_rdy,
  input  logic [DW-1:0]  cmd_dat,
  input  logic [4:0]     cmd_len,
  input  logic [1:0]     cmd_iom,
  input  logic           cmd_oen,
  input  logic           cmd_rce,
  input  logic           cmd_sso,
  output logic           rsp_vld,
  input  logic           rsp_rdy,
  output logic [DW-1:0]  rsp_dat,
  output logic           spi_sclk,
  output logic           spi_ss_n,
  output logic [3:0]     spi_io_o,
  output logic [3:0]     spi_io_e,
  input  logic [3:0]     spi_io_i
);

  localparam logic [1:0] IOM_DUAL = 2'b01;
  localparam logic [1:0] IOM_QUAD = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [DW-1:0]   shreg_q, shreg_d;
  logic [4:0]      beat_q, beat_d;
  logic [CDW-1:0]  phase_q, phase_d;
  logic [CDW-1:0]  div_q, div_d;
  logic [1:0]      iom_q, iom_d;
  logic            oen_q, oen_d;
  logic            rce_q, rce_d;

  logic            cmd_rdy_d, rsp_vld_d, sclk_d, ss_n_d;
  logic [DW-1:0]   rsp_dat_d;
  logic [3:0]      io_o_d, io_e_d;

  logic            accept, tick, rise, fall, last;

  assign accept = (state_q == IDLE) && cmd_vld && cmd_rdy;
  assign tick   = (state_q == SHIFT) && (phase_q == '0);
  assign rise   = tick && !spi_sclk;
  assign fall   = tick && spi_sclk;
  assign last   = fall && (beat_q == '0);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = SHIFT;
      SHIFT:   if (last) state_d = rce_q ? RESP : IDLE;
      RESP:    if (rsp_vld && rsp_rdy) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath and output next values
  always_comb begin
    shreg_d   = shreg_q;
    beat_d    = beat_q;
    phase_d   = phase_q;
    div_d     = div_q;
    iom_d     = iom_q;
    oen_d     = oen_q;
    rce_d     = rce_q;
    sclk_d    = spi_sclk;
    ss_n_d    = spi_ss_n;
    rsp_dat_d = rsp_dat;
    io_o_d    = 4'b0000;
    io_e_d    = 4'b0000;

    if (accept) begin
      shreg_d = cmd_dat;
      beat_d  = cmd_len;
      phase_d = div;
      div_d   = div;
      iom_d   = cmd_iom;
      oen_d   = cmd_oen;
      rce_d   = cmd_rce;
      ss_n_d  = ~cmd_sso;
      sclk_d  = 1'b0;
    end else if (tick) begin
      phase_d = div_q;
      sclk_d  = ~spi_sclk;
      if (rise) begin
        case (iom_q)
          IOM_QUAD: shreg_d = (shreg_q << 4) | DW'(spi_io_i);
          IOM_DUAL: shreg_d = (shreg_q << 2) | DW'(spi_io_i[1:0]);
          default:  shreg_d = (shreg_q << 1) | DW'(spi_io_i[1]);
        endcase
      end else if (beat_q != '0) begin
        beat_d = beat_q - 5'd1;
      end
    end else if (state_q == SHIFT) begin
      phase_d = phase_q - CDW'(1);
    end

    if (last && rce_q) rsp_dat_d = shreg_q;

    // IO lanes follow the post-update shift register so they lead SCLK rise
    if (state_d == SHIFT) begin
      case (iom_d)
        IOM_QUAD: begin
          io_o_d = shreg_d[DW-1 -: 4];
          io_e_d = oen_d ? 4'b1111 : 4'b0000;
        end
        IOM_DUAL: begin
          io_o_d = {2'b00, shreg_d[DW-1 -: 2]};
          io_e_d = oen_d ? 4'b0011 : 4'b0000;
        end
        default: begin
          io_o_d = {3'b000, shreg_d[DW-1]};
          io_e_d = oen_d ? 4'b0001 : 4'b0000;
        end
      endcase
    end

    cmd_rdy_d = (state_d == IDLE);
    rsp_vld_d = (state_d == RESP);
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      shreg_q  <= '0;
      beat_q   <= '0;
      phase_q  <= '0;
      div_q    <= '0;
      iom_q    <= '0;
      oen_q    <= 1'b0;
      rce_q    <= 1'b0;
      cmd_rdy  <= 1'b1;
      rsp_vld  <= 1'b0;
      rsp_dat  <= '0;
      spi_sclk <= 1'b0;
      spi_ss_n <= 1'b1;
      spi_io_o <= 4'b0000;
      spi_io_e <= 4'b0000;
    end else begin
      shreg_q  <= shreg_d;
      beat_q   <= beat_d;
      phase_q  <= phase_d;
      div_q    <= div_d;
      iom_q    <= iom_d;
      oen_q    <= oen_d;
      rce_q    <= rce_d;
      cmd_rdy  <= cmd_rdy_d;
      rsp_vld  <= rsp_vld_d;
      rsp_dat  <= rsp_dat_d;
      spi_sclk <= sclk_d;
      spi_ss_n <= ss_n_d;
      spi_io_o <= io_o_d;
      spi_io_e <= io_e_d;
    end
  end

endmodule

// File: tb/tb_spi_ser.sv
// Self-checking bench for spi_ser: directed and randomized commands compared
// against a bit-stream reference model (transmitted bits followed by received bits).
module tb_spi_ser;
  localparam int unsigned DW  = 32;
  localparam int unsigned CDW = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic [CDW-1:0] div;
  logic           cmd_vld;
  logic           cmd_rdy;
  logic [DW-1:0]  cmd_dat;
  logic [4:0]     cmd_len;
  logic [1:0]     cmd_iom;
  logic           cmd_oen;
  logic           cmd_rce;
  logic           cmd_sso;
  logic           rsp_vld;
  logic           rsp_rdy;
  logic [DW-1:0]  rsp_dat;
  logic           spi_sclk;
  logic           spi_ss_n;
  logic [3:0]     spi_io_o;
  logic [3:0]     spi_io_e;
  logic [3:0]     spi_io_i;

  int compared   = 0;
  int mismatched = 0;

  spi_ser #(.DW(DW), .CDW(CDW)) dut (
    .clk(clk), .rst(rst), .div(div),
    .cmd_vld(cmd_vld), .cmd_rdy(cmd_rdy), .cmd_dat(cmd_dat), .cmd_len(cmd_len),
    .cmd_iom(cmd_iom), .cmd_oen(cmd_oen), .cmd_rce(cmd_rce), .cmd_sso(cmd_sso),
    .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy), .rsp_dat(rsp_dat),
    .spi_sclk(spi_sclk), .spi_ss_n(spi_ss_n), .spi_io_o(spi_io_o),
    .spi_io_e(spi_io_e), .spi_io_i(spi_io_i)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_cmd_rdy"}, 32'(cmd_rdy), 32'd1);
    check({tag, "_rsp_vld"}, 32'(rsp_vld), 32'd0);
    check({tag, "_rsp_dat"}, 32'(rsp_dat), 32'd0);
    check({tag, "_sclk"},    32'(spi_sclk), 32'd0);
    check({tag, "_ss_n"},    32'(spi_ss_n), 32'd1);
    check({tag, "_io_o"},    32'(spi_io_o), 32'd0);
    check({tag, "_io_e"},    32'(spi_io_e), 32'd0);
  endtask

  // Present a command and return at the falling clk edge of the first SHIFT cycle
  task automatic start_cmd(input logic [31:0] dat, input int len, input int iom,
                           input bit oen, input bit rce, input bit sso, input int dv);
    int n;
    @(negedge clk);
    cmd_dat = dat;
    cmd_len = 5'(len);
    cmd_iom = 2'(iom);
    cmd_oen = oen;
    cmd_rce = rce;
    cmd_sso = sso;
    div     = CDW'(dv);
    cmd_vld = 1'b1;
    n = 0;
    while (!cmd_rdy && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("cmd_rdy_wait", 32'(cmd_rdy), 32'd1);
    @(posedge clk);
    @(negedge clk);
    cmd_vld = 1'b0;
    cmd_dat = 32'($urandom);
    div     = CDW'($urandom);
  endtask

  task automatic run_cmd(input logic [31:0] dat, input int len, input int iom,
                         input bit oen, input bit rce, input bit sso, input int dv,
                         input bit loopback, input int stall);
    bit          q[$];
    logic [3:0]  rx[34];
    logic [3:0]  exp_io, exp_e, prev_io;
    logic [31:0] exp_rsp;
    bit          prev_sclk;
    int          n, beats, rises, hi, cyc;

    n     = (iom == 2) ? 4 : (iom == 1) ? 2 : 1;
    beats = len + 1;
    for (int i = DW - 1; i >= 0; i--) q.push_back(dat[i]);
    for (int k = 0; k < 34; k++) rx[k] = 4'($urandom);
    spi_io_i = loopback ? 4'b0000 : rx[0];

    start_cmd(dat, len, iom, oen, rce, sso, dv);
    check("ss_n_accept", 32'(spi_ss_n), 32'(!sso));
    exp_e = !oen ? 4'b0000 : (n == 4) ? 4'b1111 : (n == 2) ? 4'b0011 : 4'b0001;
    check("io_e_shift", 32'(spi_io_e), 32'(exp_e));

    prev_sclk = 1'b0;
    prev_io   = spi_io_o;
    rises = 0;
    hi    = 0;
    cyc   = 0;
    while (!(cmd_rdy || rsp_vld) && cyc < 5000) begin
      if (loopback) spi_io_i = {2'b00, spi_io_o[0], 1'b0};
      if (spi_sclk && !prev_sclk) begin
        // Lines presented during the low phase must be the next n stream bits
        exp_io = 4'b0000;
        for (int j = 0; j < n; j++) exp_io[n-1-j] = q[rises*n + j];
        check("io_o_beat", 32'(prev_io), 32'(exp_io));
        if (loopback) q.push_back(q[rises]);
        else if (n == 1) q.push_back(rx[rises][1]);
        else for (int j = n - 1; j >= 0; j--) q.push_back(rx[rises][j]);
        rises++;
        if (!loopback && rises < 34) spi_io_i = rx[rises];
      end
      if (spi_sclk) hi++;
      prev_sclk = spi_sclk;
      prev_io   = spi_io_o;
      cyc++;
      @(negedge clk);
    end

    check("shift_cycles", 32'(cyc), 32'(2 * beats * (dv + 1)));
    check("beats", 32'(rises), 32'(beats));
    check("sclk_high_cycles", 32'(hi), 32'(beats * (dv + 1)));
    check("sclk_end", 32'(spi_sclk), 32'd0);
    check("io_e_end", 32'(spi_io_e), 32'd0);
    check("ss_n_hold", 32'(spi_ss_n), 32'(!sso));

    exp_rsp = '0;
    for (int i = 0; i < DW; i++) exp_rsp[DW-1-i] = q[q.size() - DW + i];

    if (rce) begin
      check("rsp_vld", 32'(rsp_vld), 32'd1);
      check("rsp_dat", rsp_dat, exp_rsp);
      check("cmd_rdy_in_resp", 32'(cmd_rdy), 32'd0);
      for (int s = 0; s < stall; s++) begin
        @(negedge clk);
        check("rsp_vld_stall", 32'(rsp_vld), 32'd1);
        check("rsp_dat_stall", rsp_dat, exp_rsp);
        check("cmd_rdy_stall", 32'(cmd_rdy), 32'd0);
      end
      rsp_rdy = 1'b1;
      @(negedge clk);
      rsp_rdy = 1'b0;
      check("rsp_vld_after", 32'(rsp_vld), 32'd0);
      check("cmd_rdy_after", 32'(cmd_rdy), 32'd1);
    end else begin
      check("rsp_vld_none", 32'(rsp_vld), 32'd0);
      check("cmd_rdy_back", 32'(cmd_rdy), 32'd1);
      check("sclk_fell_prev", 32'(prev_sclk), 32'd1);
    end
  endtask

  initial begin
    bit saw_rsp;

    rst      = 1'b1;
    div      = '0;
    cmd_vld  = 1'b0;
    cmd_dat  = '0;
    cmd_len  = '0;
    cmd_iom  = '0;
    cmd_oen  = 1'b0;
    cmd_rce  = 1'b0;
    cmd_sso  = 1'b0;
    rsp_rdy  = 1'b0;
    spi_io_i = '0;
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    rst = 1'b0;
    @(negedge clk);

    // Single mode loopback: received byte equals the transmitted top byte
    run_cmd(32'hA500_0000, 7, 0, 1'b1, 1'b1, 1'b1, 1, 1'b1, 0);

    // Quad, fastest clock, no response
    run_cmd(32'h1234_5678, 7, 2, 1'b1, 1'b0, 1'b1, 0, 1'b0, 0);

    // Response stalled for 10 cycles
    run_cmd(32'($urandom), 11, 1, 1'b1, 1'b1, 1'b1, 2, 1'b0, 10);

    // Full 128-bit quad wrap and reserved IO mode
    run_cmd(32'($urandom), 31, 2, 1'b0, 1'b1, 1'b1, 0, 1'b0, 1);
    run_cmd(32'($urandom), 5, 3, 1'b1, 1'b1, 1'b1, 1, 1'b0, 0);

    // Slave select held low between commands, released by a sso=0 command
    run_cmd(32'($urandom), 3, 0, 1'b1, 1'b0, 1'b1, 0, 1'b0, 0);
    repeat (3) @(negedge clk);
    check("ss_n_idle_low", 32'(spi_ss_n), 32'd0);
    run_cmd(32'($urandom), 3, 0, 1'b1, 1'b0, 1'b0, 0, 1'b0, 0);
    repeat (2) @(negedge clk);
    check("ss_n_idle_high", 32'(spi_ss_n), 32'd1);

    // Reset in the middle of a transfer
    start_cmd(32'($urandom), 15, 2, 1'b1, 1'b1, 1'b1, 2);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset_values("mid_rst");
    saw_rsp = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (rsp_vld || spi_sclk) saw_rsp = 1'b1;
    end
    check("no_rsp_after_rst", 32'(saw_rsp), 32'd0);

    // Randomized commands
    for (int t = 0; t < 16; t++) begin
      run_cmd(32'($urandom), int'($urandom_range(0, 31)), int'($urandom_range(0, 3)),
              1'($urandom), 1'($urandom), 1'($urandom), int'($urandom_range(0, 3)),
              1'b0, int'($urandom_range(0, 3)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
